// File: rtl/mips_mem_arbiter.sv
// Purpose: shares one unified memory between the multicycle MIPS core and a host loader/debug port, with host-driven core halt.
// Latency: grant, memory mux and CPU read data are combinational; host read data returns one cycle after its grant.
// Backpressure: a losing CPU sees cpu_stall and must hold its request; the host holds its request until host_gnt.
// Build option: define MEM_ARB_FAIRNESS_EN for host-priority arbitration bounded by HOST_MAX_BURST (default: strict CPU priority).
module mips_mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int HOST_MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic          cpu_halted,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_halt,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    logic halt_q;
    logic cpu_gnt;
    // High when the host should win a cycle in which both sides request.
    logic host_first;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] BURST_LIMIT = 4'(HOST_MAX_BURST);

    // Consecutive host grants taken while the CPU was kept waiting.
    logic [3:0] burst_cnt;

    assign host_first = (burst_cnt != BURST_LIMIT);

    // Count host wins against a waiting CPU; any CPU grant, idle CPU or halt restarts the window.
    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt <= 4'd0;
        end else if (halt_q || !cpu_req || cpu_gnt) begin
            burst_cnt <= 4'd0;
        end else if (host_gnt && (burst_cnt != BURST_LIMIT)) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end
`else
    // The burst limit has no meaning under strict CPU priority.
    localparam int unused_host_max_burst = HOST_MAX_BURST;

    assign host_first = 1'b0;
`endif

    // Decide the memory owner for this cycle; a halted core is never granted.
    always_comb begin
        host_gnt = 1'b0;
        cpu_gnt  = 1'b0;
        if (halt_q) begin
            host_gnt = host_req;
        end else if (host_req && cpu_req) begin
            host_gnt = host_first;
            cpu_gnt  = !host_first;
        end else begin
            host_gnt = host_req;
            cpu_gnt  = cpu_req;
        end
    end

    // Route the owner onto the memory port; with no owner, park on the CPU bus with writes off.
    always_comb begin
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        if (host_gnt) begin
            mem_adr   = host_adr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign cpu_stall  = halt_q | (cpu_req & ~cpu_gnt);
    assign cpu_halted = halt_q;

    // Freeze/release the core one cycle after the host changes its halt level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= host_halt;
        end
    end

    // Capture read data for a granted host read; valid is a one-cycle pulse, data holds until the next read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            if (host_gnt && !host_we) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
module tb_mips_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall, cpu_halted;
    logic          host_req, host_we;
    logic [AW-1:0] host_adr;
    logic [DW-1:0] host_wdata;
    logic          host_halt, host_gnt, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    mips_mem_arbiter #(.AW(AW), .DW(DW), .HOST_MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_halted(cpu_halted),
        .host_req(host_req), .host_we(host_we), .host_adr(host_adr), .host_wdata(host_wdata),
        .host_halt(host_halt), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory seen by the DUT (combinational read, write at the edge) and the bench's own copy.
    logic [DW-1:0] tb_mem  [256];
    logic [DW-1:0] ref_mem [256];
    assign mem_rdata = tb_mem[mem_adr[7:0]];
    always @(posedge clk) if (mem_we) tb_mem[mem_adr[7:0]] <= mem_wdata;

    // Reference state: halt level, host wins in a row against a waiting CPU, pending read return.
    bit          m_halt;
    int          m_streak;
    bit          m_rv;
    logic [31:0] m_rd;
    bit          last_hg, last_cg;
    int          n_cmp, n_bad;
    int          cnt_h, cnt_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: check combinational and registered outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          hg, cg, ew;
        logic [31:0] ea, ed, rv;
        @(negedge clk);
        if (m_halt) begin
            hg = host_req; cg = 1'b0;
        end else if (host_req && cpu_req) begin
`ifdef MEM_ARB_FAIRNESS_EN
            hg = (m_streak < MAXB);
`else
            hg = 1'b0;
`endif
            cg = !hg;
        end else begin
            hg = host_req; cg = cpu_req;
        end
        ea = hg ? host_adr : cpu_adr;
        ed = hg ? host_wdata : cpu_wdata;
        ew = hg ? host_we : (cg ? cpu_we : 1'b0);
        rv = ref_mem[ea[7:0]];
        chk("host_gnt",    {31'd0, host_gnt},    {31'd0, hg});
        chk("cpu_stall",   {31'd0, cpu_stall},   {31'd0, m_halt | (cpu_req & !cg)});
        chk("cpu_halted",  {31'd0, cpu_halted},  {31'd0, m_halt});
        chk("mem_we",      {31'd0, mem_we},      {31'd0, ew});
        chk("mem_adr",     mem_adr,              ea);
        chk("mem_wdata",   mem_wdata,            ed);
        chk("cpu_rdata",   cpu_rdata,            rv);
        chk("host_rvalid", {31'd0, host_rvalid}, {31'd0, m_rv});
        chk("host_rdata",  host_rdata,           m_rd);
        last_hg = hg; last_cg = cg;
        if (hg) cnt_h++;
        if (cg) cnt_c++;
        @(posedge clk);
        if (ew) ref_mem[ea[7:0]] = ed;
        if (!reset) begin
            m_halt = 0; m_streak = 0; m_rv = 0; m_rd = '0;
        end else begin
            m_rv = hg && !host_we;
            if (m_rv) m_rd = rv;
            if (m_halt || cg || !cpu_req) m_streak = 0;
            else if (hg && m_streak < MAXB) m_streak = m_streak + 1;
            m_halt = host_halt;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end
        n_cmp = 0; n_bad = 0; cnt_h = 0; cnt_c = 0;
        m_halt = 0; m_streak = 0; m_rv = 0; m_rd = '0;
        cpu_req = 0; cpu_we = 0; cpu_adr = '0; cpu_wdata = '0;
        host_req = 1; host_we = 0; host_adr = 32'h10; host_wdata = '0; host_halt = 0;
        reset = 0;

        // Reset with a host read pending: no read return may leak out of reset.
        @(posedge clk); #1;
        cycle(); cycle();
        reset = 1; host_req = 0;
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_rdata",  host_rdata,           32'd0);
        chk("rst_halted", {31'd0, cpu_halted},  32'd0);

        // CPU alone fetching from address 0.
        cpu_req = 1; cpu_adr = '0;
        repeat (8) cycle();

        // Host write then read of 0x40 with the CPU idle.
        cpu_req = 0;
        host_req = 1; host_we = 1; host_adr = 32'h40; host_wdata = 32'hDEADBEEF;
        cycle();
        host_we = 0;
        cycle();
        host_req = 0;
        chk("rd_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("rd_rdata",  host_rdata,           32'hDEADBEEF);
        cycle();

        // Sustained contention.
        cpu_req = 1; cpu_adr = 32'h4; host_req = 1; host_we = 0; host_adr = 32'h8;
        cnt_h = 0; cnt_c = 0;
        repeat (20) cycle();
`ifdef MEM_ARB_FAIRNESS_EN
        chk("cont_host", cnt_h, 32'd16);
        chk("cont_cpu",  cnt_c, 32'd4);
`else
        chk("cont_host", cnt_h, 32'd0);
        chk("cont_cpu",  cnt_c, 32'd20);
`endif
        cpu_req = 0;
        cycle();
        chk("drop_cpu_hg", {31'd0, last_hg}, 32'd1);
        host_req = 0;
        cycle();

        // Halt raised during a CPU fetch: fetch completes, core frozen next cycle.
        cpu_req = 1; cpu_adr = 32'hC; host_halt = 1;
        cycle();
        chk("halt_fetch", {31'd0, last_cg}, 32'd1);
        chk("halted_now", {31'd0, cpu_halted}, 32'd1);
        cnt_h = 0;
        host_req = 1; host_we = 1;
        for (int i = 0; i < 16; i++) begin
            host_adr = 32'h80 + i; host_wdata = $urandom;
            cycle();
        end
        chk("halt_wr16", cnt_h, 32'd16);
        host_we = 0;
        for (int i = 0; i < 16; i++) begin
            host_adr = 32'h80 + i;
            cycle();
        end
        host_req = 0; host_halt = 0;
        cycle();
        cycle();
        chk("released", {31'd0, cpu_halted}, 32'd0);

        // Randomized traffic; the host keeps its request stable until granted.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) != 0);
            cpu_req = $urandom_range(0, 3) != 0;
            cpu_we = $urandom_range(0, 3) == 0;
            cpu_adr = {24'd0, 8'($urandom)};
            cpu_wdata = $urandom;
            if ($urandom_range(0, 19) == 0) host_halt = !host_halt;
            if (last_hg || !host_req) begin
                host_req = $urandom_range(0, 2) != 0;
                host_we = $urandom_range(0, 1);
                host_adr = {24'd0, 8'($urandom)};
                host_wdata = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
